// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, LSB first.
//
// Brings the asynchronous rx pin through a two-flop synchroniser and watches
// the synchronised line for a start bit. Each bit is then sampled at a fixed
// cycle offset from the point where the start bit was detected. A correctly
// framed byte is presented on rx_data with a one-cycle rx_valid strobe. A stop
// bit sampled low produces a one-cycle rx_frame_err strobe. After that the
// receiver waits for the line to return high before it can re-arm, so a held
// low line or a break condition never starts a new frame.
//
// Ports
//   clk           in   1  system clock
//   rst           in   1  synchronous active-high reset
//   rx            in   1  asynchronous serial input, idle high
//   rx_data       out  8  last correctly framed byte, held until the next good frame
//   rx_valid      out  1  one-cycle strobe: rx_data updated this cycle
//   rx_frame_err  out  1  one-cycle strobe: stop bit sampled low
//   rx_bsy        out  1  high while a frame is in progress (state != IDLE)
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int          SYSCLOCK = 100000000,
    parameter int          BAUDRATE = 12000000,
    parameter logic [15:0] STARTMID = 16'd4,
    parameter logic [15:0] BIT0MID  = 16'd13,
    parameter logic [15:0] BIT1MID  = 16'd21,
    parameter logic [15:0] BIT2MID  = 16'd29,
    parameter logic [15:0] BIT3MID  = 16'd38,
    parameter logic [15:0] BIT4MID  = 16'd46,
    parameter logic [15:0] BIT5MID  = 16'd54,
    parameter logic [15:0] BIT6MID  = 16'd63,
    parameter logic [15:0] BIT7MID  = 16'd71,
    parameter logic [15:0] STOPMID  = 16'd79
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_bsy
);

    // The sample offsets are worked out from these two rates. This guard
    // stops elaboration if the rates cannot give at least two clocks per bit.
    if (SYSCLOCK < 2 * BAUDRATE) begin : g_rate_check
        $error("uart_rx: SYSCLOCK must be at least twice BAUDRATE");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    // Registers and their next-state values
    logic        sync1_q;
    logic        rx_s_q;
    state_t      state_q,  state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [7:0]  shift_q,  shift_d;
    logic [7:0]  data_q,   data_d;
    logic        valid_q,  valid_d;
    logic        ferr_q,   ferr_d;
    logic        bsy_q,    bsy_d;

    logic        bit_mid;

    // True at the centre of any of the eight data bits
    assign bit_mid = (cnt_q == BIT0MID) || (cnt_q == BIT1MID) ||
                     (cnt_q == BIT2MID) || (cnt_q == BIT3MID) ||
                     (cnt_q == BIT4MID) || (cnt_q == BIT5MID) ||
                     (cnt_q == BIT6MID) || (cnt_q == BIT7MID);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The cycle the low level is first seen counts as offset 0.
                cnt_d = 16'd0;
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = 16'd1;
                end
            end

            START: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == STARTMID) begin
                    if (rx_s_q) begin
                        // The line went high again, so this was a glitch.
                        state_d = IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_mid) begin
                    // LSB arrives first and ends up in bit 0 after 8 shifts.
                    shift_d = {rx_s_q, shift_q[7:1]};
                end
                if (cnt_q == BIT7MID) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == STOPMID) begin
                    if (rx_s_q) begin
                        // Going back to IDLE before the transmitter finishes
                        // its stop bit lets back-to-back frames be caught.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // The counter saturates here because a break can last
                // indefinitely.
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (rx_s_q) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        bsy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so that
            // every flop samples values from before the clock edge.
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            bsy_q   <= 1'b0;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            bsy_q   <= bsy_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_bsy       = bsy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : directed bench for uart_rx.
//
// A bit-level line driver builds frames with the same bit boundaries as a
// 100 MHz / 12 Mbaud transmitter: an 84-clock frame, with optional +/-1 clock
// jitter per bit. The expected bytes are pushed into a queue when a frame is
// driven. They are popped and compared whenever rx_valid is seen on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_bsy;

    int total;
    int bad;
    int n_valid;
    int n_ferr;
    int n_bsy;

    logic [7:0] exp_q[$];
    logic [7:0] last_good;

    localparam int FRAME_CLKS = 84;

    uart_rx dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_bsy      (rx_bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample DUT outputs on the falling edge and score any strobes.
    task automatic step();
        @(negedge clk);
        if (rx_bsy) n_bsy++;
        if (rx_frame_err) n_ferr++;
        if (rx_valid) begin
            n_valid++;
            check("bsy_low_at_valid", {31'd0, rx_bsy}, 32'd0);
            check("no_ferr_with_valid", {31'd0, rx_frame_err}, 32'd0);
            if (exp_q.size() > 0) begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end else begin
                check("unexpected_valid", {31'd0, rx_valid}, 32'd0);
            end
        end
    endtask

    // Line level at clock t of a frame. Bit i starts at round(i*100/12),
    // and jitter moves every odd-numbered boundary one clock later.
    function automatic logic line_val(input logic [7:0] d, input logic stop_v,
                                      input bit jit, input int t);
        int b;
        b = 0;
        for (int i = 1; i <= 9; i++) begin
            int e;
            e = (i * 100 + 6) / 12 + ((jit && (i % 2 == 1)) ? 1 : 0);
            if (t >= e) b = i;
        end
        if (b == 0) return 1'b0;
        if (b == 9) return stop_v;
        return d[b-1];
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit jit);
        if (stop_v) begin
            exp_q.push_back(d);
            last_good = d;
        end
        for (int t = 0; t < FRAME_CLKS; t++) begin
            rx = line_val(d, stop_v, jit, t);
            step();
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int v0;
        int f0;
        int b0;
        total     = 0;
        bad       = 0;
        n_valid   = 0;
        n_ferr    = 0;
        n_bsy     = 0;
        last_good = 8'h00;
        rx        = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_data",  {24'd0, rx_data}, 32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_ferr",  {31'd0, rx_frame_err}, 32'd0);
        check("reset_bsy",   {31'd0, rx_bsy}, 32'd0);
        idle(5);

        // 1: single byte
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(10);
        check("t1_valid_count", n_valid - v0, 1);
        check("t1_ferr_count",  n_ferr - f0, 0);
        check("t1_hold_data",   {24'd0, rx_data}, 32'h A5);

        // 2: 256 back-to-back bytes
        v0 = n_valid; f0 = n_ferr;
        for (int k = 0; k < 256; k++) send_frame(k[7:0], 1'b1, 1'b0);
        idle(10);
        check("t2_valid_count", n_valid - v0, 256);
        check("t2_ferr_count",  n_ferr - f0, 0);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: two-cycle glitch
        v0 = n_valid; f0 = n_ferr; b0 = n_bsy;
        rx = 1'b0; step(); step();
        idle(20);
        check("t3_bsy_cycles",  n_bsy - b0, 4);
        check("t3_valid_count", n_valid - v0, 0);
        check("t3_ferr_count",  n_ferr - f0, 0);
        check("t3_bsy_idle",    {31'd0, rx_bsy}, 32'd0);

        // 4: bad stop bit, line held low, then a good frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        for (int i = 0; i < 200; i++) step();
        check("t4_ferr_count",  n_ferr - f0, 1);
        check("t4_valid_count", n_valid - v0, 0);
        check("t4_data_held",   {24'd0, rx_data}, {24'd0, last_good});
        check("t4_bsy_held",    {31'd0, rx_bsy}, 32'd1);
        idle(10);
        check("t4_bsy_release", {31'd0, rx_bsy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        check("t4_good_valid",  n_valid - v0, 1);
        check("t4_ferr_total",  n_ferr - f0, 1);

        // 5: reset at offset 40 of a frame
        v0 = n_valid; f0 = n_ferr;
        for (int t = 0; t < 40; t++) begin
            rx = line_val(8'h81, 1'b1, 1'b0, t);
            step();
        end
        rst = 1'b1; rx = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_data",  {24'd0, rx_data}, 32'd0);
        check("t5_rst_bsy",   {31'd0, rx_bsy}, 32'd0);
        idle(100);
        check("t5_no_valid",  n_valid - v0, 0);
        check("t5_no_ferr",   n_ferr - f0, 0);
        check("t5_data_zero", {24'd0, rx_data}, 32'd0);
        check("t5_bsy_idle",  {31'd0, rx_bsy}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);
        check("t5_after_valid", n_valid - v0, 1);

        // 6: jittered bit period
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h55, 1'b1, 1'b1);
        idle(10);
        check("t6_valid_count", n_valid - v0, 1);
        check("t6_ferr_count",  n_ferr - f0, 0);
        check("t6_data",        {24'd0, rx_data}, 32'h55);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
